// File: rtl/latch_ctrl_pkg.sv
// Shared opcode and state encodings for the latch bank controller.
package latch_ctrl_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam int PULSE_CNT_W = 4;

endpackage

// File: rtl/latch_pulse_gen.sv
// Pulse-width counter and latch drive decode. The counter is loaded while the
// controller sits in SETUP, so it holds GATE_CYC-1 on the first PULSE cycle.
module latch_pulse_gen #(
    parameter int LAT_Width = 8,
    parameter int GATE_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 active,
    input  logic                 data_window,
    input  logic [1:0]           op,
    input  logic [LAT_Width-1:0] data,
    output logic                 done,
    output logic                 lat_gate,
    output logic                 lat_aset,
    output logic                 lat_aclr,
    output logic [LAT_Width-1:0] lat_d
);
    import latch_ctrl_pkg::*;

    localparam logic [PULSE_CNT_W-1:0] LOAD_VAL = PULSE_CNT_W'(GATE_CYC - 1);

    logic [PULSE_CNT_W-1:0] cnt;

    // Count down the remaining pulse cycles; the last PULSE cycle reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (active && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Exactly one drive is active in PULSE, selected by the captured opcode.
    always_comb begin
        done     = active && (cnt == '0);
        lat_gate = active && (op == OP_WRITE);
        lat_aset = active && (op == OP_SET);
        lat_aclr = active && (op == OP_CLEAR);
        lat_d    = (data_window && (op == OP_WRITE)) ? data : '0;
    end

endmodule

// File: rtl/latch_ctrl.sv
// Command-driven controller for an external latch bank: drives gate/set/clear
// pulses, reads the bank back and reports the value with a mismatch flag.
module latch_ctrl #(
    parameter int LAT_Width = 8,
    parameter int GATE_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [LAT_Width-1:0] cmd_data,
    output logic                 lat_aset,
    output logic                 lat_aclr,
    output logic                 lat_gate,
    output logic [LAT_Width-1:0] lat_d,
    input  logic [LAT_Width-1:0] lat_q,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LAT_Width-1:0] rsp_data,
    output logic                 rsp_err
);
    import latch_ctrl_pkg::*;

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [1:0]           op_reg;
    logic [LAT_Width-1:0] data_reg;
    logic [LAT_Width-1:0] expected;
    logic                 accept;
    logic                 pulse_done;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = cmd_valid && cmd_ready;

    // State register; reset wins over any handshake at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reads skip straight to CHECK; everything else walks through the pulse.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_next = (cmd_op == OP_READ) ? ST_CHECK : ST_SETUP;
            ST_SETUP: state_next = ST_PULSE;
            ST_PULSE: if (pulse_done) state_next = ST_HOLD;
            ST_HOLD:  state_next = ST_CHECK;
            ST_CHECK: state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Capture the command at the accept edge; data only matters for writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg   <= OP_WRITE;
            data_reg <= '0;
        end else if (accept) begin
            op_reg   <= cmd_op;
            data_reg <= (cmd_op == OP_WRITE) ? cmd_data : '0;
        end
    end

    // Value the bank should hold after the pulse for the captured opcode.
    always_comb begin
        expected = data_reg;
        case (op_reg)
            OP_SET:   expected = '1;
            OP_CLEAR: expected = '0;
            default:  expected = data_reg;
        endcase
    end

    // Sample the readback in CHECK and hold it untouched through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == ST_CHECK) begin
            rsp_data <= lat_q;
            rsp_err  <= (op_reg != OP_READ) && (lat_q != expected);
        end
    end

    latch_pulse_gen #(
        .LAT_Width (LAT_Width),
        .GATE_CYC  (GATE_CYC)
    ) u_pulse_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (state == ST_SETUP),
        .active      (state == ST_PULSE),
        .data_window ((state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD)),
        .op          (op_reg),
        .data        (data_reg),
        .done        (pulse_done),
        .lat_gate    (lat_gate),
        .lat_aset    (lat_aset),
        .lat_aclr    (lat_aclr),
        .lat_d       (lat_d)
    );

endmodule
